// File: rtl/cra_diag_seq_if.sv
// cra_diag_seq_if: console command/response handshake plus CTL DIAG strobes and EBUS data
//   master: console side (drives commands, consumes responses, returns EBUS read data)
//   slave:  cra_diag_seq (accepts commands, drives strobes/diag/EBUS, returns responses)
interface cra_diag_seq_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [0:10] cmdAdr;
  logic        rspValid;
  logic        rspReady;
  logic [0:10] rspData;
  logic        rspAux;
  logic        diagLoadFunc05x;
  logic        diagReadFunc14x;
  logic [4:6]  diag;
  logic        ebusDriving;
  logic [0:5]  ebusOut;
  logic [0:5]  ebusIn;
  modport master (
    output cmdValid, cmdOp, cmdAdr, rspReady, ebusIn,
    input  cmdReady, rspValid, rspData, rspAux, diagLoadFunc05x, diagReadFunc14x, diag, ebusDriving, ebusOut
  );
  modport slave (
    input  cmdValid, cmdOp, cmdAdr, rspReady, ebusIn,
    output cmdReady, rspValid, rspData, rspAux, diagLoadFunc05x, diagReadFunc14x, diag, ebusDriving, ebusOut
  );
endinterface

// File: rtl/cra_diag_seq.sv
// cra_diag_seq: CRA diag initiator sequencing DIAG LOAD 05x / READ 14x phases
//   clk, RESET: clock and synchronous active-high reset
//   bus (slave): command in, response out, CTL DIAG strobes/diag[4:6], EBUS data out/in
module cra_diag_seq #(
  parameter int STROBE_CYCLES = 2
) (
  input logic          clk,
  input logic          RESET,
  cra_diag_seq_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PH1  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_PH2  = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;
  localparam logic [3:0] LP_N   = (STROBE_CYCLES < 1) ? 4'd1 : 4'(STROBE_CYCLES);
  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic [0:10] r_adr;
  logic [4:6]  r_diag;
  logic [0:5]  r_ebus;
  logic        r_ld;
  logic        r_rd;
  logic        r_drv;
  logic        r_rsp_v;
  logic [0:10] r_rsp_d;
  logic        r_rsp_aux;
  logic        w_accept;
  logic        w_last;
  logic        w_load;
  logic        w_cmd_load;
  function automatic logic [4:6] f_diag(input logic [1:0] op, input logic ph2);
    f_diag = op == 2'b01 ? {2'b10, ph2} :
             op == 2'b10 ? {2'b01, ph2} :
             op == 2'b00 ? (ph2 ? 3'b001 : 3'b010) : 3'b000;
  endfunction
  assign w_accept   = bus.cmdValid && r_state == S_IDLE;
  assign w_last     = r_cnt == 4'd0;
  assign w_load     = r_op == 2'b00;
  assign w_cmd_load = bus.cmdOp == 2'b00;
  assign bus.cmdReady        = r_state == S_IDLE;
  assign bus.rspValid        = r_rsp_v;
  assign bus.rspData         = r_rsp_d;
  assign bus.rspAux          = r_rsp_aux;
  assign bus.diagLoadFunc05x = r_ld;
  assign bus.diagReadFunc14x = r_rd;
  assign bus.diag            = r_diag;
  assign bus.ebusDriving     = r_drv;
  assign bus.ebusOut         = r_ebus;
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_op      <= 2'b00;
      r_adr     <= '0;
      r_diag    <= '0;
      r_ebus    <= '0;
      r_ld      <= 1'b0;
      r_rd      <= 1'b0;
      r_drv     <= 1'b0;
      r_rsp_v   <= 1'b0;
      r_rsp_d   <= '0;
      r_rsp_aux <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= bus.cmdOp;
          r_adr   <= bus.cmdAdr;
          r_state <= S_PH1;
          r_cnt   <= LP_N - 4'd1;
          r_diag  <= f_diag(bus.cmdOp, 1'b0);
          r_ld    <= w_cmd_load;
          r_rd    <= !w_cmd_load;
          r_drv   <= w_cmd_load;
          r_ebus  <= w_cmd_load ? {1'b0, bus.cmdAdr[0:4]} : 6'd0;
        end
        S_PH1: if (w_last) begin
          // RDSP is single-phase and skips the gap straight into the response
          r_state   <= r_op == 2'b11 ? S_RSP : S_GAP;
          r_rsp_v   <= r_op == 2'b11;
          r_diag    <= '0;
          r_ebus    <= '0;
          r_ld      <= 1'b0;
          r_rd      <= 1'b0;
          r_drv     <= 1'b0;
          r_rsp_d   <= w_load ? r_rsp_d : {5'b0, bus.ebusIn};
          r_rsp_aux <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_GAP: begin
          r_state <= S_PH2;
          r_cnt   <= LP_N - 4'd1;
          r_diag  <= f_diag(r_op, 1'b1);
          r_ld    <= w_load;
          r_rd    <= !w_load;
          r_drv   <= w_load;
          r_ebus  <= w_load ? r_adr[5:10] : 6'd0;
        end
        S_PH2: if (w_last) begin
          r_state   <= S_RSP;
          r_rsp_v   <= 1'b1;
          r_diag    <= '0;
          r_ebus    <= '0;
          r_ld      <= 1'b0;
          r_rd      <= 1'b0;
          r_drv     <= 1'b0;
          // PH1 sample already sits in the low six bits
          r_rsp_d   <= w_load ? r_adr : {bus.ebusIn[1:5], r_rsp_d[5:10]};
          r_rsp_aux <= w_load ? 1'b0 : bus.ebusIn[0];
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_RSP: if (bus.rspReady) begin
          r_rsp_v <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
